// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, state encoding and operand helper for the divider
package div_pkg;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

   localparam logic [5:0] DivIters = 6'd32;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Magnitude of a signed operand; unsigned operands pass through unchanged.
   function automatic logic [RegBus-1:0] op_mag(input logic [RegBus-1:0] v, input logic is_signed);
      return (is_signed && v[RegBus-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div.sv
// rtl/div.sv - iterative radix-2 restoring divider for DIV/DIVU, result held until start drops
module div
   import div_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    signed_div_i,
   input  logic [RegBus-1:0]       opdata1_i,
   input  logic [RegBus-1:0]       opdata2_i,
   input  logic                    start_i,
   input  logic                    annul_i,
   output logic [DoubleRegBus-1:0] result_o,
   output logic                    ready_o
);

   div_state_e              state_q, state_d;
   logic [5:0]              cnt_q, cnt_d;
   logic [DoubleRegBus-1:0] work_q, work_d;
   logic [RegBus-1:0]       divisor_q, divisor_d;
   logic                    signed_q, signed_d;
   logic                    sign1_q, sign1_d;
   logic                    sign2_q, sign2_d;
   logic [DoubleRegBus-1:0] result_q, result_d;
   logic                    ready_q, ready_d;

   // work_q = {partial remainder, dividend bits still to consume / quotient bits produced}
   logic [RegBus:0]   partial;
   logic [RegBus:0]   trial;
   logic [RegBus-1:0] quot_fix;
   logic [RegBus-1:0] rem_fix;

   assign partial  = {work_q[DoubleRegBus-1:RegBus], work_q[RegBus-1]};
   assign trial    = partial - {1'b0, divisor_q};
   assign quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~work_q[RegBus-1:0] + 1'b1)
                                                       : work_q[RegBus-1:0];
   assign rem_fix  = (signed_q && sign1_q) ? (~work_q[DoubleRegBus-1:RegBus] + 1'b1)
                                           : work_q[DoubleRegBus-1:RegBus];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      signed_d  = signed_q;
      sign1_d   = sign1_q;
      sign2_d   = sign2_q;
      result_d  = result_q;
      ready_d   = ready_q;
      unique case (state_q)
         DivFree: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = DivByZero;
               end else begin
                  state_d   = DivOn;
                  cnt_d     = '0;
                  work_d    = {{RegBus{1'b0}}, op_mag(opdata1_i, signed_div_i)};
                  divisor_d = op_mag(opdata2_i, signed_div_i);
                  signed_d  = signed_div_i;
                  sign1_d   = opdata1_i[RegBus-1];
                  sign2_d   = opdata2_i[RegBus-1];
               end
            end
         end
         DivByZero: begin
            state_d  = DivEnd;
            work_d   = '0;
            result_d = '0;
            ready_d  = 1'b1;
         end
         DivOn: begin
            if (annul_i) begin
               state_d = DivFree;
            end else if (cnt_q != DivIters) begin
               // A negative trial means the divisor did not fit: keep the partial remainder.
               if (trial[RegBus])
                  work_d = {partial[RegBus-1:0], work_q[RegBus-2:0], 1'b0};
               else
                  work_d = {trial[RegBus-1:0], work_q[RegBus-2:0], 1'b1};
               cnt_d = cnt_q + 6'd1;
            end else begin
               state_d  = DivEnd;
               result_d = {rem_fix, quot_fix};
               ready_d  = 1'b1;
            end
         end
         DivEnd: begin
            if (!start_i) begin
               state_d  = DivFree;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: state_d = DivFree;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         signed_q  <= 1'b0;
         sign1_q   <= 1'b0;
         sign2_q   <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         signed_q  <= signed_d;
         sign1_q   <= sign1_d;
         sign2_q   <= sign2_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed and randomized checks of div against an arithmetic reference
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int errors = 0;
   int checks = 0;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one operation, optionally scramble operands mid-flight, check latency and result.
   task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input bit scramble, input int hold);
      int n;
      logic [63:0] exp;
      exp = ref_div(s, a, b);
      @(negedge clk);
      signed_div = s; op1 = a; op2 = b; start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (scramble) begin
            op1 = $urandom; op2 = $urandom; signed_div = ~signed_div;
         end
      end while (!ready && n < 40);
      chk({tag, " ready"}, {63'd0, ready}, 64'd1);
      chk({tag, " latency"}, 64'(n - 1), (b == 32'd0) ? 64'd1 : 64'd33);
      chk({tag, " result"}, result, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " hold result"}, result, exp);
         chk({tag, " hold ready"}, {63'd0, ready}, 64'd1);
      end
      start = 1'b0;
      @(negedge clk);
      chk({tag, " drop ready"}, {63'd0, ready}, 64'd0);
      chk({tag, " drop result"}, result, 64'd0);
   endtask

   initial begin
      int seen;
      logic [31:0] ra;
      logic [31:0] rb;
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset ready", {63'd0, ready}, 64'd0);
      chk("reset result", result, 64'd0);
      rst = 1'b0;

      run("u100/7", 1'b0, 32'd100, 32'd7, 1'b0, 0);
      chk("u100/7 const", ref_div(1'b0, 32'd100, 32'd7), {32'h2, 32'hE});
      run("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
      chk("s-7/2 const", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run("u-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
      run("div0", 1'b1, 32'h1234_5678, 32'd0, 1'b0, 0);
      run("u div0", 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
      run("minint/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      run("s5/-3", 1'b1, 32'd5, 32'hFFFF_FFFD, 1'b0, 0);
      run("hold5", 1'b0, 32'd1000, 32'd33, 1'b0, 5);
      run("scramble", 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 0);

      // Annul at DivOn cycle 10: no result ever appears.
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd999; op2 = 32'd4; start = 1'b1;
      repeat (10) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0; start = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) seen++;
      end
      chk("annul ready cycles", 64'(seen), 64'd0);
      run("after annul", 1'b1, 32'hFFFF_FC18, 32'd7, 1'b0, 0);

      // Reset in the middle of an iteration.
      @(negedge clk);
      signed_div = 1'b1; op1 = 32'd12345; op2 = 32'd11; start = 1'b1;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst ready", {63'd0, ready}, 64'd0);
      chk("midrst result", result, 64'd0);
      rst = 1'b0; start = 1'b0;
      run("after rst", 1'b1, 32'd12345, 32'hFFFF_FFF5, 1'b0, 0);

      for (int k = 0; k < 16; k++) begin
         ra = $urandom;
         rb = (k % 3 == 0) ? ($urandom & 32'hFF) : $urandom;
         if (k == 5) rb = 32'd1;
         if (k == 9) rb = 32'd0;
         run($sformatf("rand%0d", k), 1'(k & 1), ra, rb, 1'(k % 4 == 2), k % 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
